uart_tx_core: RTL and testbench

8N1 UART transmitter; the transmit-side counterpart to the team's UART receiver, driving the serial line out of the FPGA.
- Accepts a byte through a single-cycle start handshake and serialises it as: start bit, 8 data bits LSB first, 1 stop bit.
- Bit timing comes from an internal clock-enable counter on clk. No derived clock; all logic runs in the clk domain.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_tx_core.sv | 122 ++++++++++++
 tb/tb_uart_tx_core.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line states, data width, bit-period helper.
package uart_pkg;

   localparam int unsigned UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // Clock cycles per line bit, truncating integer division.
   function automatic int unsigned clks_per_bit(input int unsigned freq_hz,
                                                input int unsigned bit_rate);
      return freq_hz / bit_rate;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter; tick is a registered pulse aligned with the terminal count.
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CNT_W-1:0] cnt;

   // Count 0..CLKS_PER_BIT-1 while enabled; tick is raised one edge early so it
   // is high in exactly the cycle where the count sits at its terminal value.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (en) begin
         if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         tick <= (cnt == CNT_W'(CLKS_PER_BIT - 2));
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int unsigned clk_freq  = 1000000,
   parameter int unsigned baud_rate = 9600
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   txStart,
   input  logic [UART_DATA_W-1:0] txData,
   output logic                   tx,
   output logic                   busy,
   output logic                   doneTx
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(clk_freq, baud_rate);
   localparam int unsigned IDX_W        = 3;

   if (CLKS_PER_BIT < 2) begin : g_cpb_check
      $error("uart_tx_core: clk_freq/baud_rate must be at least 2");
   end

   uart_state_t            state, state_nxt;
   logic [UART_DATA_W-1:0] shift_q, shift_nxt;
   logic [IDX_W-1:0]       idx_q, idx_nxt;
   logic                   tx_nxt, busy_nxt, done_nxt;
   logic                   bit_end;
   logic                   baud_clear;
   logic                   baud_en;

   // Counter is held at zero while idle, so every frame starts on a clean bit period.
   assign baud_clear = (state == IDLE);
   assign baud_en    = (state != IDLE);

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clear(baud_clear),
      .en   (baud_en),
      .tick (bit_end)
   );

   // State and registered line outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
         doneTx  <= 1'b0;
      end else begin
         state   <= state_nxt;
         shift_q <= shift_nxt;
         idx_q   <= idx_nxt;
         tx      <= tx_nxt;
         busy    <= busy_nxt;
         doneTx  <= done_nxt;
      end
   end

   // Next state and next values of the registered outputs.
   always_comb begin
      state_nxt = state;
      shift_nxt = shift_q;
      idx_nxt   = idx_q;
      tx_nxt    = tx;
      busy_nxt  = busy;
      done_nxt  = 1'b0;

      case (state)
         IDLE: begin
            tx_nxt   = 1'b1;
            busy_nxt = 1'b0;
            if (txStart) begin
               shift_nxt = txData;
               state_nxt = START;
               tx_nxt    = 1'b0;
               busy_nxt  = 1'b1;
            end
         end
         START: begin
            tx_nxt = 1'b0;
            if (bit_end) begin
               state_nxt = DATA;
               idx_nxt   = '0;
               tx_nxt    = shift_q[0];
            end
         end
         DATA: begin
            tx_nxt = shift_q[0];
            if (bit_end) begin
               shift_nxt = {1'b0, shift_q[UART_DATA_W-1:1]};
               if (idx_q == IDX_W'(UART_DATA_W - 1)) begin
                  state_nxt = STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  idx_nxt = idx_q + IDX_W'(1);
                  tx_nxt  = shift_q[1];
               end
            end
         end
         STOP: begin
            tx_nxt = 1'b1;
            if (bit_end) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: frame-level model plus directed frames.
module tb_uart_tx_core;

   localparam int N0 = 1000000 / 9600;
   localparam int N1 = 50000000 / 115200;

   logic       clk;
   logic       rst;
   logic       txStart, txStart2;
   logic [7:0] txData, txData2;
   logic       tx, busy, doneTx;
   logic       tx2, busy2, doneTx2;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   logic [9:0] samp;
   int         edges_q[$];

   uart_tx_core #(.clk_freq(1000000), .baud_rate(9600)) u0 (
      .clk(clk), .rst(rst), .txStart(txStart), .txData(txData),
      .tx(tx), .busy(busy), .doneTx(doneTx)
   );

   uart_tx_core #(.clk_freq(50000000), .baud_rate(115200)) u1 (
      .clk(clk), .rst(rst), .txStart(txStart2), .txData(txData2),
      .tx(tx2), .busy(busy2), .doneTx(doneTx2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Frame model: k counts cycles since the first start-bit cycle; bit = k / n.
   typedef struct {
      bit         active;
      int         k;
      logic [7:0] b;
      logic       tx;
      logic       busy;
      logic       done;
   } mdl_t;

   mdl_t m0, m1;

   function automatic mdl_t step(input mdl_t m, input logic r, input logic st,
                                 input logic [7:0] d, input int n);
      mdl_t o;
      int   bi;
      o = m;
      if (r) begin
         o.active = 1'b0; o.tx = 1'b1; o.busy = 1'b0; o.done = 1'b0;
      end else if (!m.active) begin
         o.done = 1'b0;
         if (st) begin
            o.active = 1'b1; o.k = 0; o.b = d; o.tx = 1'b0; o.busy = 1'b1;
         end else begin
            o.tx = 1'b1; o.busy = 1'b0;
         end
      end else begin
         o.k = m.k + 1;
         if (o.k == 10 * n) begin
            o.active = 1'b0; o.tx = 1'b1; o.busy = 1'b0; o.done = 1'b1;
         end else begin
            bi     = o.k / n;
            o.tx   = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : m.b[bi-1];
            o.busy = 1'b1;
            o.done = 1'b0;
         end
      end
      return o;
   endfunction

   // Advance both models on the same edges the DUTs sample.
   always @(posedge clk) begin
      m0 = step(m0, rst, txStart, txData, N0);
      m1 = step(m1, rst, txStart2, txData2, N1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model0", {29'd0, tx, busy, doneTx}, {29'd0, m0.tx, m0.busy, m0.done});
         chk("model1", {29'd0, tx2, busy2, doneTx2}, {29'd0, m1.tx, m1.busy, m1.done});
      end
   end

   function automatic logic tx_of(input int s);
      return (s == 0) ? tx : tx2;
   endfunction
   function automatic logic busy_of(input int s);
      return (s == 0) ? busy : busy2;
   endfunction
   function automatic logic done_of(input int s);
      return (s == 0) ? doneTx : doneTx2;
   endfunction
   function automatic logic [7:0] data_of(input int s);
      return (s == 0) ? txData : txData2;
   endfunction

   task automatic drive(input int s, input logic st, input logic [7:0] d);
      if (s == 0) begin
         txStart = st; txData = d;
      end else begin
         txStart2 = st; txData2 = d;
      end
   endtask

   task automatic idle_watch(input int s, input int cycles, output int bad);
      bad = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (tx_of(s) !== 1'b1 || busy_of(s) !== 1'b0 || done_of(s) !== 1'b0) bad++;
      end
   endtask

   // Send one byte and observe it: midpoint samples, tx edges, doneTx position.
   // Returns on the doneTx cycle so a caller can chain the next start there.
   task automatic frame(input int s, input logic [7:0] d, input int n,
                        input int poke_k, input int abort_k, input bit chain,
                        input logic [7:0] nxt, output logic [7:0] got,
                        output int done_k);
      logic prev;
      samp   = '0;
      edges_q.delete();
      done_k = -1;
      drive(s, 1'b1, d);
      @(negedge clk);
      drive(s, 1'b0, d);
      chk("start_latency", {30'd0, tx_of(s), busy_of(s)}, 32'b01);
      prev = tx_of(s);
      for (int k = 0; k <= 10 * n + 2; k++) begin
         if (k > 0 && tx_of(s) !== prev) edges_q.push_back(k);
         prev = tx_of(s);
         if ((k % n) == (n / 2) && (k / n) < 10) samp[k/n] = tx_of(s);
         if (done_of(s) === 1'b1) begin
            done_k = k;
            break;
         end
         if (k == poke_k) drive(s, 1'b1, 8'hFF);
         if (k == poke_k + 1) drive(s, 1'b0, data_of(s));
         if (k == poke_k + 200) drive(s, 1'b0, 8'h5A);
         if (k == abort_k) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_line", {30'd0, tx_of(s), busy_of(s)}, 32'b10);
            got = samp[8:1];
            return;
         end
         @(negedge clk);
      end
      got = samp[8:1];
      chk("frame_len", done_k, 10 * n);
      chk("done_busy", {31'd0, busy_of(s)}, 32'd0);
      chk("start_bit", {31'd0, samp[0]}, 32'd0);
      chk("stop_bit", {31'd0, samp[9]}, 32'd1);
      chk("byte", {24'd0, got}, {24'd0, d});
      if (chain) drive(s, 1'b1, nxt);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] got;
      int         dk;
      int         bad;

      rst = 1'b1;
      txStart = 1'b1; txData = 8'hA5;
      txStart2 = 1'b0; txData2 = 8'h00;

      // Reset held three cycles with txStart high.
      repeat (3) begin
         @(negedge clk);
         cmp_en = 1'b1;
         chk("reset_out", {29'd0, tx, busy, doneTx}, 32'b100);
      end
      rst = 1'b0;
      txStart = 1'b0;
      idle_watch(0, 20, bad);
      chk("post_reset_idle", bad, 0);

      // Single byte 0xA5 with midpoint samples.
      frame(0, 8'hA5, N0, -5, -1, 1'b0, 8'h00, got, dk);
      chk("a5_samples", {22'd0, samp}, {22'd0, 10'b1101001010});
      chk("a5_frame_len", dk, 1040);
      idle_watch(0, 10, bad);
      chk("a5_tail_idle", bad, 0);

      // Start while busy is ignored; mid-frame txData changes have no effect.
      frame(0, 8'h3C, N0, 300, -1, 1'b0, 8'h00, got, dk);
      chk("busy_start_byte", {24'd0, got}, 32'h3C);
      idle_watch(0, 3 * N0, bad);
      chk("no_second_frame", bad, 0);

      // Back-to-back: second start issued in the doneTx cycle.
      frame(0, 8'h00, N0, -5, -1, 1'b1, 8'hFF, got, dk);
      chk("b2b_edges_n", edges_q.size(), 1);
      if (edges_q.size() > 0) chk("b2b_stop_rise", edges_q[0], 936);
      frame(0, 8'hFF, N0, -5, -1, 1'b0, 8'h00, got, dk);
      chk("ff_edges_n", edges_q.size(), 1);
      if (edges_q.size() > 0) chk("ff_first_rise", edges_q[0], 104);
      idle_watch(0, 10, bad);

      // Reset during data bit 4 of 0x81, then a clean 0x55.
      frame(0, 8'h81, N0, -5, 5 * N0 + N0 / 2, 1'b0, 8'h00, got, dk);
      idle_watch(0, 2 * N0, bad);
      chk("abort_no_done", bad, 0);
      frame(0, 8'h55, N0, -5, -1, 1'b0, 8'h00, got, dk);
      chk("after_abort_byte", {24'd0, got}, 32'h55);
      idle_watch(0, 10, bad);

      // 50 MHz / 115200 instance: 434 cycles per bit.
      chk("n1_value", N1, 434);
      frame(1, 8'hC3, N1, -5, -1, 1'b0, 8'h00, got, dk);
      chk("c3_frame_len", dk, 4340);
      chk("c3_edges_n", edges_q.size(), 3);
      if (edges_q.size() == 3) begin
         chk("c3_edge0", edges_q[0], 434);
         chk("c3_edge1", edges_q[1], 1302);
         chk("c3_edge2", edges_q[2], 3038);
      end
      idle_watch(1, 10, bad);
      chk("c3_tail_idle", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
